// File: rtl/multi_alarm_clock.sv
// ----------------------------------------------------------------------------
// multi_alarm_clock
//
// Packed-BCD time-of-day clock with NUM_ALARMS independently armed hh:mm
// alarms, a 12h/24h display mode, an auto-stop ring timeout and an optional
// snooze. Time is kept internally in 24h BCD; the 12h view is derived
// combinationally. A prescaler divides clk by CLK_DIV to make the 1 s tick.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   -> SNOOZED state, snooze input defers the ring by SNOOZE_MIN
//   undefined -> snooze input is ignored, FSM is IDLE/RINGING only
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   enable         1 = prescaler/time advance, 0 = frozen (no ticks/matches)
//   mode_24h       display/load format, 1 = 24h, 0 = 12h with pm flag
//   load_time      load hh_load/mm_load/ss_load/pm_load into time
//   load_alarm     load hh_load/mm_load/pm_load into alarm alarm_sel
//   alarm_sel      alarm index for load_alarm/alarm_toggle
//   alarm_toggle   1-cycle pulse: invert armed bit of alarm_sel
//   alarm_stop     stop a ringing or snoozed alarm
//   snooze         defer the ringing alarm by SNOOZE_MIN minutes
//   hh/mm/ss_load  packed BCD load values
//   pm_load        PM flag for loads in 12h mode
//   hh, mm, ss     packed BCD current time (display format)
//   pm             1 when internal hour >= 12
//   tick           1-cycle pulse on each seconds increment
//   alarm_on       1 while ringing
//   alarm_src      index of the alarm that caused the current ring/snooze
//   alarm_armed    armed bit per alarm
//   load_err       1-cycle pulse when a load is rejected
// ----------------------------------------------------------------------------
module multi_alarm_clock #(
    parameter int NUM_ALARMS     = 4,
    parameter int SEL_W          = 2,
    parameter int CLK_DIV        = 10,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode_24h,
    input  logic                  load_time,
    input  logic                  load_alarm,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic                  alarm_toggle,
    input  logic                  alarm_stop,
    input  logic                  snooze,
    input  logic [7:0]            hh_load,
    input  logic [7:0]            mm_load,
    input  logic [7:0]            ss_load,
    input  logic                  pm_load,
    output logic [7:0]            hh,
    output logic [7:0]            mm,
    output logic [7:0]            ss,
    output logic                  pm,
    output logic                  tick,
    output logic                  alarm_on,
    output logic [SEL_W-1:0]      alarm_src,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic                  load_err
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RC_W  = $clog2(RING_TIMEOUT_S + 1);

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return (8'(v[7:4]) * 8'd10) + 8'(v[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [7:0] b);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(b / 8'd10);
        o = 4'(b % 8'd10);
        return {t, o};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Increment a BCD value, wrapping to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Convert a (validated) load hour into internal 24h BCD.
    function automatic logic [7:0] hour_to_24(input logic [7:0] h_bcd,
                                              input logic       pm_f,
                                              input logic       m24);
        logic [7:0] h;
        h = bcd2bin(h_bcd);
        if (!m24) begin
            if (h == 8'd12)
                h = pm_f ? 8'd12 : 8'd0;
            else if (pm_f)
                h = h + 8'd12;
        end
        return bin2bcd(h);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            hh_q, hh_d;
    logic [7:0]            mm_q, mm_d;
    logic [7:0]            ss_q, ss_d;
    logic                  tick_q, tick_d;
    logic                  err_q, err_d;

    logic [7:0]            alm_hh_q [NUM_ALARMS];
    logic [7:0]            alm_mm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed_q;

    logic [SEL_W-1:0]      src_q;
    logic                  alarm_on_q;
    logic [RC_W-1:0]       ring_cnt_q;

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZED} state_t;
    logic [7:0]            wake_hh_q, wake_mm_q;
    logic [7:0]            wake_hh_d, wake_mm_d;
    logic                  wake_hit;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_RINGING} state_t;
    logic                  unused_snooze;
    assign unused_snooze = snooze;
`endif
    state_t                state_q;

    // ------------------------------------------------------------------
    // Load validation
    // ------------------------------------------------------------------
    logic       hh_ok, mm_ok, ss_ok, sel_ok;
    logic       lt_ok, la_ok;
    logic [7:0] hh_ld24;

    always_comb begin
        hh_ok  = bcd_ok(hh_load) &&
                 (mode_24h ? (hh_load <= 8'h23)
                           : ((hh_load >= 8'h01) && (hh_load <= 8'h12)));
        mm_ok  = bcd_ok(mm_load) && (mm_load <= 8'h59);
        ss_ok  = bcd_ok(ss_load) && (ss_load <= 8'h59);
        sel_ok = (32'(alarm_sel) < NUM_ALARMS);
        lt_ok  = load_time  && hh_ok && mm_ok && ss_ok;
        la_ok  = load_alarm && hh_ok && mm_ok && sel_ok;
        err_d  = (load_time  && !(hh_ok && mm_ok && ss_ok)) ||
                 (load_alarm && !(hh_ok && mm_ok && sel_ok));
        hh_ld24 = hour_to_24(hh_load, pm_load, mode_24h);
    end

    // ------------------------------------------------------------------
    // Prescaler and time-of-day next state
    // ------------------------------------------------------------------
    logic       wrap, tick_ev;
    logic [7:0] hh_inc, mm_inc, ss_inc;

    assign wrap    = enable && (cnt_q == CNT_W'(CLK_DIV - 1));
    // A valid time load overrides the increment, so no tick is emitted then.
    assign tick_ev = wrap && !lt_ok;
    assign tick_d  = tick_ev;

    always_comb begin
        ss_inc = bcd_inc(ss_q, 8'h59);
        mm_inc = mm_q;
        hh_inc = hh_q;
        if (ss_q == 8'h59) begin
            mm_inc = bcd_inc(mm_q, 8'h59);
            if (mm_q == 8'h59)
                hh_inc = bcd_inc(hh_q, 8'h23);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        hh_d  = hh_q;
        mm_d  = mm_q;
        ss_d  = ss_q;
        if (lt_ok) begin
            cnt_d = '0;
            hh_d  = hh_ld24;
            mm_d  = mm_load;
            ss_d  = ss_load;
        end else if (enable) begin
            if (wrap) begin
                cnt_d = '0;
                hh_d  = hh_inc;
                mm_d  = mm_inc;
                ss_d  = ss_inc;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            hh_q   <= 8'h00;
            mm_q   <= 8'h00;
            ss_q   <= 8'h00;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hh_q   <= hh_d;
            mm_q   <= mm_d;
            ss_q   <= ss_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Alarm registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_hh_q[i] <= 8'h00;
                alm_mm_q[i] <= 8'h00;
            end
            armed_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (la_ok && (alarm_sel == SEL_W'(i))) begin
                    alm_hh_q[i] <= hh_ld24;
                    alm_mm_q[i] <= mm_load;
                end
                if (alarm_toggle && (alarm_sel == SEL_W'(i)))
                    armed_q[i] <= ~armed_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Match detection against the time being registered on this tick.
    // Descending scan so the lowest matching index is the one kept.
    // ------------------------------------------------------------------
    logic             match;
    logic [SEL_W-1:0] match_idx;
    logic             src_disarm;
    logic             ring_last;

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (tick_ev && (ss_inc == 8'h00) && armed_q[i] &&
                (alm_hh_q[i] == hh_inc) && (alm_mm_q[i] == mm_inc)) begin
                match     = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    // Disarming the alarm that owns the ring ends it.
    always_comb begin
        src_disarm = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_toggle && (alarm_sel == SEL_W'(i)) &&
                (src_q == SEL_W'(i)) && armed_q[i])
                src_disarm = 1'b1;
        end
    end

    assign ring_last = (ring_cnt_q == RC_W'(RING_TIMEOUT_S - 1));

`ifdef ALARM_SNOOZE_EN
    // Wake time = current hh:mm + SNOOZE_MIN, wrapping at midnight.
    logic [7:0] wk_h, wk_m;
    always_comb begin
        wk_h = bcd2bin(hh_q);
        wk_m = bcd2bin(mm_q) + 8'(SNOOZE_MIN);
        if (wk_m >= 8'd60) begin
            wk_m = wk_m - 8'd60;
            wk_h = (wk_h == 8'd23) ? 8'd0 : wk_h + 8'd1;
        end
        wake_hh_d = bin2bcd(wk_h);
        wake_mm_d = bin2bcd(wk_m);
    end

    assign wake_hit = tick_ev && (ss_inc == 8'h00) &&
                      (hh_inc == wake_hh_q) && (mm_inc == wake_mm_q);
`endif

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            alarm_on_q <= 1'b0;
            src_q      <= '0;
            ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
            wake_hh_q  <= 8'h00;
            wake_mm_q  <= 8'h00;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match) begin
                        state_q    <= ST_RINGING;
                        alarm_on_q <= 1'b1;
                        src_q      <= match_idx;
                        ring_cnt_q <= '0;
                    end
                end
                ST_RINGING: begin
                    // Stop has priority over snooze.
                    if (alarm_stop || src_disarm) begin
                        state_q    <= ST_IDLE;
                        alarm_on_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_q    <= ST_SNOOZED;
                        alarm_on_q <= 1'b0;
                        wake_hh_q  <= wake_hh_d;
                        wake_mm_q  <= wake_mm_d;
`endif
                    end else if (tick_ev) begin
                        if (ring_last) begin
                            state_q    <= ST_IDLE;
                            alarm_on_q <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + RC_W'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZED: begin
                    if (alarm_stop || src_disarm) begin
                        state_q    <= ST_IDLE;
                        alarm_on_q <= 1'b0;
                    end else if (wake_hit) begin
                        state_q    <= ST_RINGING;
                        alarm_on_q <= 1'b1;
                        ring_cnt_q <= '0;
                    end
                end
`endif
                default: begin
                    state_q    <= ST_IDLE;
                    alarm_on_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; hour shown in 12h form converts internal 00 -> 12, 13..23 -> 01..11
    // ------------------------------------------------------------------
    logic [7:0] hbin;

    always_comb begin
        hbin = bcd2bin(hh_q);
        pm   = (hbin >= 8'd12);
        if (mode_24h)
            hh = hh_q;
        else if (hbin == 8'd0)
            hh = 8'h12;
        else if (hbin > 8'd12)
            hh = bin2bcd(hbin - 8'd12);
        else
            hh = hh_q;
    end

    assign mm          = mm_q;
    assign ss          = ss_q;
    assign tick        = tick_q;
    assign alarm_on    = alarm_on_q;
    assign alarm_src   = src_q;
    assign alarm_armed = armed_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed testbench for multi_alarm_clock (CLK_DIV=10, 4 alarms).
module tb_multi_alarm_clock;

    localparam int NUM_ALARMS = 4;
    localparam int SEL_W      = 2;

    logic clk = 1'b0;
    logic reset = 1'b0, enable = 1'b0, mode_24h = 1'b0;
    logic load_time = 1'b0, load_alarm = 1'b0, alarm_toggle = 1'b0;
    logic alarm_stop = 1'b0, snooze = 1'b0, pm_load = 1'b0;
    logic [SEL_W-1:0] alarm_sel = '0;
    logic [7:0] hh_load = 8'h00, mm_load = 8'h00, ss_load = 8'h00;
    logic [7:0] hh, mm, ss;
    logic pm, tick, alarm_on, load_err;
    logic [SEL_W-1:0] alarm_src;
    logic [NUM_ALARMS-1:0] alarm_armed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .NUM_ALARMS(NUM_ALARMS), .SEL_W(SEL_W), .CLK_DIV(10),
        .SNOOZE_MIN(5), .RING_TIMEOUT_S(60)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode_24h(mode_24h),
        .load_time(load_time), .load_alarm(load_alarm), .alarm_sel(alarm_sel),
        .alarm_toggle(alarm_toggle), .alarm_stop(alarm_stop), .snooze(snooze),
        .hh_load(hh_load), .mm_load(mm_load), .ss_load(ss_load), .pm_load(pm_load),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick(tick), .alarm_on(alarm_on),
        .alarm_src(alarm_src), .alarm_armed(alarm_armed), .load_err(load_err)
    );

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic pulse_load_time(input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s, input logic p);
        hh_load = h; mm_load = m; ss_load = s; pm_load = p; load_time = 1'b1;
        @(negedge clk);
        load_time = 1'b0;
    endtask

    task automatic pulse_load_alarm(input logic [SEL_W-1:0] sel, input logic [7:0] h,
                                    input logic [7:0] m, input logic p);
        alarm_sel = sel; hh_load = h; mm_load = m; pm_load = p; load_alarm = 1'b1;
        @(negedge clk);
        load_alarm = 1'b0;
    endtask

    task automatic pulse_toggle(input logic [SEL_W-1:0] sel);
        alarm_sel = sel; alarm_toggle = 1'b1;
        @(negedge clk);
        alarm_toggle = 1'b0;
    endtask

    task automatic pulse_stop();
        alarm_stop = 1'b1;
        @(negedge clk);
        alarm_stop = 1'b0;
    endtask

    // Advance to the negedge just after the next seconds tick (bounded).
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 40);
        if (tick !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL tick_timeout: no tick seen within %0d cycles", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; mode_24h = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (hh !== 8'h12) begin n_fail++; $display("FAIL reset_hh12: got %h want 12", hh); end
        n_checks++; if (pm !== 1'b0) begin n_fail++; $display("FAIL reset_pm: got %b want 0", pm); end
        n_checks++; if ({mm, ss} !== 16'h0000) begin n_fail++; $display("FAIL reset_mmss: got %h%h want 0000", mm, ss); end
        n_checks++; if ({tick, alarm_on, load_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {tick, alarm_on, load_err}); end
        n_checks++; if ({alarm_src, alarm_armed} !== 6'd0) begin n_fail++; $display("FAIL reset_alarms: got src=%0d armed=%b want 0/0000", alarm_src, alarm_armed); end
        mode_24h = 1'b1; #1;
        n_checks++; if (hh !== 8'h00) begin n_fail++; $display("FAIL reset_hh24: got %h want 00", hh); end
        mode_24h = 1'b0;
        @(negedge clk);
        reset = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 9) begin
                n_checks++; if ({tick, ss} !== 9'h000) begin n_fail++; $display("FAIL pre_tick: got tick=%b ss=%h want 0/00", tick, ss); end
            end
            if (k == 10) begin
                n_checks++; if ({tick, ss} !== 9'h101) begin n_fail++; $display("FAIL first_tick: got tick=%b ss=%h want 1/01", tick, ss); end
            end
        end
    endtask

    task automatic test_rollover();
        mode_24h = 1'b0;
        pulse_load_time(8'h11, 8'h59, 8'h59, 1'b0);
        n_checks++; if ({hh, mm, ss, pm, load_err} !== {24'h115959, 2'b00}) begin n_fail++; $display("FAIL load12_am: got %h:%h:%h pm=%b err=%b want 11:59:59 0 0", hh, mm, ss, pm, load_err); end
        wait_tick();
        n_checks++; if ({hh, mm, ss, pm} !== {24'h120000, 1'b1}) begin n_fail++; $display("FAIL roll12_noon: got %h:%h:%h pm=%b want 12:00:00 pm=1", hh, mm, ss, pm); end
        mode_24h = 1'b1;
        pulse_load_time(8'h23, 8'h59, 8'h59, 1'b1);
        n_checks++; if ({hh, pm} !== {8'h23, 1'b1}) begin n_fail++; $display("FAIL load24: got %h pm=%b want 23 pm=1", hh, pm); end
        wait_tick();
        n_checks++; if ({hh, mm, ss, pm} !== {24'h000000, 1'b0}) begin n_fail++; $display("FAIL roll24: got %h:%h:%h pm=%b want 00:00:00 pm=0", hh, mm, ss, pm); end
        mode_24h = 1'b0;
        pulse_load_time(8'h11, 8'h59, 8'h59, 1'b1);
        n_checks++; if ({hh, pm} !== {8'h11, 1'b1}) begin n_fail++; $display("FAIL load12_pm: got %h pm=%b want 11 pm=1", hh, pm); end
        wait_tick();
        n_checks++; if ({hh, mm, ss, pm} !== {24'h120000, 1'b0}) begin n_fail++; $display("FAIL roll12_midnight: got %h:%h:%h pm=%b want 12:00:00 pm=0", hh, mm, ss, pm); end
    endtask

    task automatic test_load_err();
        logic [7:0] bad_h [4];
        logic [7:0] bad_m [4];
        logic       md    [4];
        bad_h = '{8'h1A, 8'h10, 8'h24, 8'h00};
        bad_m = '{8'h00, 8'h60, 8'h00, 8'h00};
        md    = '{1'b1, 1'b1, 1'b1, 1'b0};
        enable = 1'b0;   // freeze so "unchanged" is exact: time is 00:00:00
        for (int i = 0; i < 4; i++) begin
            mode_24h = md[i];
            pulse_load_time(bad_h[i], bad_m[i], 8'h00, 1'b0);
            n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse%0d: got %b want 1", i, load_err); end
            n_checks++; if ({mm, ss, pm} !== 17'h0) begin n_fail++; $display("FAIL err_keep%0d: got %h:%h pm=%b want 00:00 pm=0", i, mm, ss, pm); end
            @(negedge clk);
            n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL err_oneshot%0d: got %b want 0", i, load_err); end
        end
        n_checks++; if (hh !== 8'h12) begin n_fail++; $display("FAIL err_hh: got %h want 12", hh); end
        mode_24h = 1'b1;
        pulse_load_alarm(2'd0, 8'h25, 8'h00, 1'b0);
        n_checks++; if ({load_err, alarm_armed} !== 5'b10000) begin n_fail++; $display("FAIL err_alarm: got err=%b armed=%b want 1/0000", load_err, alarm_armed); end
    endtask

    task automatic test_alarm_timeout();
        enable = 1'b1; mode_24h = 1'b1;
        pulse_load_alarm(2'd1, 8'h08, 8'h32, 1'b0);
        pulse_load_alarm(2'd2, 8'h08, 8'h32, 1'b0);
        pulse_toggle(2'd1);
        pulse_toggle(2'd2);
        n_checks++; if (alarm_armed !== 4'b0110) begin n_fail++; $display("FAIL armed: got %b want 0110", alarm_armed); end
        pulse_load_time(8'h08, 8'h31, 8'h58, 1'b0);
        wait_tick();
        n_checks++; if ({ss, alarm_on} !== {8'h59, 1'b0}) begin n_fail++; $display("FAIL pre_ring: got ss=%h on=%b want 59/0", ss, alarm_on); end
        wait_tick();
        n_checks++; if ({alarm_on, alarm_src} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL ring_prio: got on=%b src=%0d want 1/1", alarm_on, alarm_src); end
        for (int i = 1; i <= 60; i++) begin
            wait_tick();
            if (i == 59) begin
                n_checks++; if (alarm_on !== 1'b1) begin n_fail++; $display("FAIL ring_59: got %b want 1", alarm_on); end
            end
            if (i == 60) begin
                n_checks++; if ({alarm_on, mm, ss} !== {1'b0, 16'h3300}) begin n_fail++; $display("FAIL ring_timeout: got on=%b %h:%h want 0 33:00", alarm_on, mm, ss); end
            end
        end
    endtask

    task automatic test_snooze();
        pulse_load_time(8'h08, 8'h31, 8'h58, 1'b0);
        wait_tick();
        wait_tick();
        n_checks++; if (alarm_on !== 1'b1) begin n_fail++; $display("FAIL snz_ring: got %b want 1", alarm_on); end
        repeat (10) wait_tick();
        n_checks++; if ({mm, ss} !== 16'h3210) begin n_fail++; $display("FAIL snz_time: got %h:%h want 32:10", mm, ss); end
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        n_checks++; if (alarm_on !== 1'b0) begin n_fail++; $display("FAIL snz_off: got %b want 0", alarm_on); end
        for (int i = 1; i <= 290; i++) begin
            wait_tick();
            if (i == 289) begin
                n_checks++; if (alarm_on !== 1'b0) begin n_fail++; $display("FAIL snz_early: got %b want 0", alarm_on); end
            end
        end
        n_checks++; if ({alarm_on, alarm_src, hh, mm, ss} !== {1'b1, 2'd1, 24'h083700}) begin n_fail++; $display("FAIL snz_wake: got on=%b src=%0d %h:%h:%h want 1 1 08:37:00", alarm_on, alarm_src, hh, mm, ss); end
`else
        n_checks++; if (alarm_on !== 1'b1) begin n_fail++; $display("FAIL snz_ignored: got %b want 1", alarm_on); end
`endif
        pulse_stop();
        n_checks++; if (alarm_on !== 1'b0) begin n_fail++; $display("FAIL stop: got %b want 0", alarm_on); end
    endtask

    task automatic test_disarm_enable();
        bit saw_tick = 1'b0;
        pulse_load_time(8'h08, 8'h31, 8'h58, 1'b0);
        wait_tick();
        wait_tick();
        n_checks++; if ({alarm_on, alarm_src} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL dis_ring: got on=%b src=%0d want 1/1", alarm_on, alarm_src); end
        pulse_toggle(2'd1);
        n_checks++; if ({alarm_on, alarm_armed} !== 5'b00100) begin n_fail++; $display("FAIL disarm: got on=%b armed=%b want 0/0100", alarm_on, alarm_armed); end
        pulse_load_time(8'h08, 8'h31, 8'h59, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tick === 1'b1) saw_tick = 1'b1;
        end
        n_checks++; if ({saw_tick, alarm_on, ss} !== {2'b00, 8'h59}) begin n_fail++; $display("FAIL frozen: got tick=%b on=%b ss=%h want 0 0 59", saw_tick, alarm_on, ss); end
        enable = 1'b1;
        wait_tick();
        n_checks++; if ({alarm_on, alarm_src, mm, ss} !== {1'b1, 2'd2, 16'h3200}) begin n_fail++; $display("FAIL resume: got on=%b src=%0d %h:%h want 1 2 32:00", alarm_on, alarm_src, mm, ss); end
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        hh_load = 8'h07; mm_load = 8'h15; ss_load = 8'h00; pm_load = 1'b0;
        alarm_sel = 2'd0; load_time = 1'b1; load_alarm = 1'b1;
        @(negedge clk);
        load_time = 1'b0; load_alarm = 1'b0;
        n_checks++; if ({hh, mm, load_err} !== {16'h0715, 1'b0}) begin n_fail++; $display("FAIL b2b_time: got %h:%h err=%b want 07:15 0", hh, mm, load_err); end
        pulse_toggle(2'd0);
        n_checks++; if (alarm_armed !== 4'b0101) begin n_fail++; $display("FAIL b2b_armed: got %b want 0101", alarm_armed); end
        pulse_load_time(8'h07, 8'h14, 8'h59, 1'b0);
        wait_tick();
        n_checks++; if ({alarm_on, alarm_src} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL b2b_ring: got on=%b src=%0d want 1/0", alarm_on, alarm_src); end
        // Reset mid-ring returns everything to the reset state at once.
        reset = 1'b0; #1;
        n_checks++; if ({alarm_on, alarm_armed, hh, mm} !== 21'd0) begin n_fail++; $display("FAIL reset_ring: got on=%b armed=%b %h:%h want 0 0000 00:00", alarm_on, alarm_armed, hh, mm); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_load_err();
        test_alarm_timeout();
        test_snooze();
        test_disarm_enable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
